// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, default operand width and arbiter state encoding.
package alu_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SLL  = 4'b0011,
    ALU_SLT  = 4'b0100,
    ALU_SLTU = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_XOR  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1010
  } alu_op_e;

  typedef enum logic {
    ST_IDLE,
    ST_HOLD
  } arb_state_e;

endpackage

// File: rtl/alu_exec.sv
// Combinational ALU: one control code and two operands in, result plus zero/illegal flags out.
module alu_exec
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic [3:0]      ctrl_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o,
  output logic            illegal_o
);

  localparam int unsigned SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  assign shamt = b_i[SHW-1:0];

  always_comb begin
    // NOTE: defaults assigned first so every branch drives both outputs and no latch is inferred.
    result_o  = '0;
    illegal_o = 1'b0;
    case (alu_op_e'(ctrl_i))
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SLL:  result_o = a_i << shamt;
      ALU_SRL:  result_o = a_i >> shamt;
      ALU_SRA:  result_o = $unsigned($signed(a_i) >>> shamt);
      ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
      ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, a_i < b_i};
      default:  illegal_o = 1'b1;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared ALU with a one-entry registered result.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [1:0][3:0]      req_ctrl,
  input  logic [1:0][XLEN-1:0] req_a,
  input  logic [1:0][XLEN-1:0] req_b,
  output logic [1:0]           rsp_valid,
  input  logic [1:0]           rsp_ready,
  output logic [XLEN-1:0]      rsp_result,
  output logic                 rsp_zero,
  output logic                 rsp_illegal
);

  arb_state_e      state_q, state_d;
  logic            owner_q, owner_d;
  logic            last_q, last_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            illegal_q, illegal_d;

  logic            grant;
  logic            rsp_xfer;
  logic            accept_ok;
  logic            req_xfer;
  logic [XLEN-1:0] alu_result;
  logic            alu_zero;
  logic            alu_illegal;

  // Grant uses only valids and last grant, so req_ready never sees the operand ports.
  assign grant     = (&req_valid) ? ~last_q : ~req_valid[0];
  assign rsp_xfer  = (state_q == ST_HOLD) && rsp_ready[owner_q];
  assign accept_ok = ~reset && ((state_q == ST_IDLE) || rsp_xfer);
  assign req_xfer  = accept_ok && (|req_valid);
  assign req_ready = req_xfer ? (2'b01 << grant) : 2'b00;

  alu_exec #(.XLEN(XLEN)) u_alu_exec (
    .ctrl_i    (req_ctrl[grant]),
    .a_i       (req_a[grant]),
    .b_i       (req_b[grant]),
    .result_o  (alu_result),
    .zero_o    (alu_zero),
    .illegal_o (alu_illegal)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    if (req_xfer) begin
      state_d   = ST_HOLD;
      owner_d   = grant;
      last_d    = grant;
      result_d  = alu_result;
      zero_d    = alu_zero;
      illegal_d = alu_illegal;
    end else if (rsp_xfer) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      result_q  <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign rsp_valid   = (state_q == ST_HOLD) ? (2'b01 << owner_q) : 2'b00;
  assign rsp_result  = result_q;
  assign rsp_zero    = zero_q;
  assign rsp_illegal = illegal_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter against a transaction-level reference model.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int XLEN = 32;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [1:0]           req_valid, req_ready, rsp_valid, rsp_ready;
  logic [1:0][3:0]      req_ctrl;
  logic [1:0][XLEN-1:0] req_a, req_b;
  logic [XLEN-1:0]      rsp_result;
  logic                 rsp_zero, rsp_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: is a result held, for whom, what it is, and who won last.
  bit          m_hold, m_owner, m_last, m_ill;
  logic [31:0] m_res;

  logic [3:0] legal_ops [10] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hA};

  alu_arbiter #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_ctrl   (req_ctrl),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_illegal(rsp_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic void ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output bit ill);
    int unsigned sh;
    sh  = b % 32;
    r   = 32'h0;
    ill = 1'b0;
    case (c)
      4'h0: r = a & b;
      4'h1: r = a | b;
      4'h2: r = a + b;
      4'h3: r = 32'(64'(a) << sh);
      4'h4: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'h5: r = (a < b) ? 32'd1 : 32'd0;
      4'h6: r = a - b;
      4'h7: r = a ^ b;
      4'h8: r = a >> sh;
      4'hA: r = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      default: ill = 1'b1;
    endcase
  endfunction

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    bit         ok, g, rsp_x;
    logic [1:0] exp_rdy;
    @(negedge clk);
    ok      = !reset && (!m_hold || rsp_ready[m_owner]);
    g       = (req_valid == 2'b11) ? !m_last : !req_valid[0];
    exp_rdy = (ok && req_valid != 2'b00) ? (g ? 2'b10 : 2'b01) : 2'b00;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("rsp_valid", 32'(rsp_valid), m_hold ? (m_owner ? 32'd2 : 32'd1) : 32'd0);
    if (m_hold) begin
      check("rsp_result", rsp_result, m_res);
      check("rsp_zero", 32'(rsp_zero), (m_res == 32'h0) ? 32'd1 : 32'd0);
      check("rsp_illegal", 32'(rsp_illegal), 32'(m_ill));
    end
    @(posedge clk);
    rsp_x = m_hold && rsp_ready[m_owner];
    if (reset) begin
      m_hold = 1'b0;
      m_last = 1'b1;
    end else if (exp_rdy != 2'b00) begin
      ref_alu(req_ctrl[g], req_a[g], req_b[g], m_res, m_ill);
      m_hold  = 1'b1;
      m_owner = g;
      m_last  = g;
    end else if (rsp_x) begin
      m_hold = 1'b0;
    end
    #1;
  endtask

  task automatic do_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    req_valid   = 2'b01;
    req_ctrl[0] = c;
    req_a[0]    = a;
    req_b[0]    = b;
    rsp_ready   = 2'b11;
    cycle();
    req_valid = 2'b00;
    #1;
    check(tag, rsp_result, exp);
    cycle();
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom % 4)
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset     = 1'b1;
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    req_ctrl  = '0;
    req_a     = '0;
    req_b     = '0;
    m_hold    = 1'b0;
    m_owner   = 1'b0;
    m_last    = 1'b1;
    m_ill     = 1'b0;
    m_res     = 32'h0;

    #2;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_result", rsp_result, 32'd0);
    check("rst_rsp_illegal", 32'(rsp_illegal), 32'd0);
    cycle();
    cycle();
    reset = 1'b0;

    // First contention after reset goes to requester 0; result one cycle later.
    req_valid   = 2'b11;
    req_ctrl[0] = ALU_ADD; req_a[0] = 32'd5;  req_b[0] = 32'd7;
    req_ctrl[1] = ALU_XOR; req_a[1] = 32'd9;  req_b[1] = 32'd3;
    rsp_ready   = 2'b11;
    #1;
    check("first_grant", 32'(req_ready), 32'd1);
    cycle();
    req_valid = 2'b00;
    #1;
    check("first_rsp_valid", 32'(rsp_valid), 32'd1);
    check("first_rsp_result", rsp_result, 32'd12);
    cycle();

    // Continuous contention alternates grants, last grant was 0.
    for (int k = 0; k < 8; k++) begin
      req_valid = 2'b11;
      for (int i = 0; i < 2; i++) begin
        req_ctrl[i] = legal_ops[$urandom % 10];
        req_a[i]    = rand_operand();
        req_b[i]    = rand_operand();
      end
      #1;
      check("rr_grant", 32'(req_ready), (k % 2 == 0) ? 32'd2 : 32'd1);
      cycle();
    end
    req_valid = 2'b00;
    cycle();

    // Back-pressure holds the result and blocks new requests.
    do_op("sub_setup", ALU_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE);
    req_valid = 2'b01;
    cycle();
    rsp_ready = 2'b00;
    req_valid = 2'b11;
    for (int k = 0; k < 3; k++) begin
      req_ctrl[0] = 4'($urandom); req_a[0] = $urandom; req_b[0] = $urandom;
      #1;
      check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      check("stall_rsp_result", rsp_result, 32'hFFFF_FFFE);
      check("stall_req_ready", 32'(req_ready), 32'd0);
      cycle();
    end
    rsp_ready = 2'b11;
    req_valid = 2'b00;
    cycle();
    cycle();

    do_op("sra", ALU_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000);
    do_op("srl", ALU_SRL, 32'h8000_0000, 32'd4, 32'h0800_0000);
    do_op("slt", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1);
    do_op("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0);
    do_op("sll", ALU_SLL, 32'd1, 32'd33, 32'd2);

    req_valid = 2'b01; req_ctrl[0] = 4'hF; req_a[0] = 32'd1; req_b[0] = 32'd1;
    cycle();
    req_valid = 2'b00;
    #1;
    check("illegal_flag", 32'(rsp_illegal), 32'd1);
    check("illegal_result", rsp_result, 32'd0);
    check("illegal_zero", 32'(rsp_zero), 32'd1);
    cycle();

    // Asynchronous reset pulse mid-hold, away from any clock edge.
    req_valid = 2'b10; req_ctrl[1] = ALU_ADD; req_a[1] = 32'd1; req_b[1] = 32'd1;
    rsp_ready = 2'b00;
    cycle();
    req_valid = 2'b00;
    #1 reset = 1'b1;
    #1;
    check("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    reset  = 1'b0;
    m_hold = 1'b0;
    m_last = 1'b1;
    req_valid = 2'b11; rsp_ready = 2'b11;
    req_ctrl[0] = ALU_OR; req_a[0] = 32'h0F; req_b[0] = 32'hF0;
    #1;
    check("post_rst_grant", 32'(req_ready), 32'd1);
    cycle();

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      req_valid = 2'($urandom);
      rsp_ready = ($urandom % 3 == 0) ? 2'($urandom) : 2'b11;
      for (int i = 0; i < 2; i++) begin
        req_ctrl[i] = ($urandom % 8 == 0) ? 4'($urandom) : legal_ops[$urandom % 10];
        req_a[i]    = rand_operand();
        req_b[i]    = rand_operand();
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
